// File: rtl/enigma_pkg.sv
// Shared letter type, FSM states, rotor/reflector wiring and mod-26 helpers
// used by enigma_core and its rotor_map datapath.
package enigma_pkg;

    typedef logic [4:0] letter_t;

    typedef enum logic [3:0] {
        S_IDLE, S_STEP, S_FR, S_FM, S_FL, S_REFL, S_BL, S_BM, S_BR, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        ROT_I, ROT_II, ROT_III, ROT_REFL
    } rotor_e;

    localparam letter_t NOTCH_I     = 5'd16;
    localparam letter_t NOTCH_II    = 5'd4;
    localparam letter_t NOTCH_III   = 5'd21;
    localparam letter_t LAST_LETTER = 5'd25;
    localparam letter_t NUM_LETTERS = 5'd26;

    // Wiring tables indexed by contact letter A=0 .. Z=25
    localparam letter_t ROTOR_I_FWD [0:25] = '{
        5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
        5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9};
    localparam letter_t ROTOR_I_INV [0:25] = '{
        5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21, 5'd25, 5'd1,  5'd4,  5'd2,
        5'd10, 5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11, 5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9};
    localparam letter_t ROTOR_II_FWD [0:25] = '{
        5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,  5'd11, 5'd7,  5'd22,
        5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13, 5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4};
    localparam letter_t ROTOR_II_INV [0:25] = '{
        5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,  5'd3,  5'd10, 5'd14,
        5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13, 5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18};
    localparam letter_t ROTOR_III_FWD [0:25] = '{
        5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
        5'd13, 5'd24, 5'd4,  5'd8,  5'd22, 5'd6,  5'd0,  5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
    localparam letter_t ROTOR_III_INV [0:25] = '{
        5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16, 5'd4,  5'd20, 5'd5,  5'd21,
        5'd13, 5'd25, 5'd7,  5'd24, 5'd8,  5'd23, 5'd9,  5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};
    localparam letter_t REFLECTOR_B [0:25] = '{
        5'd24, 5'd17, 5'd20, 5'd7,  5'd16, 5'd18, 5'd11, 5'd3,  5'd15, 5'd23, 5'd13, 5'd6,  5'd14,
        5'd10, 5'd12, 5'd8,  5'd4,  5'd1,  5'd5,  5'd25, 5'd2,  5'd22, 5'd21, 5'd9,  5'd0,  5'd19};

    // Kept within 5 bits: compare against the complement instead of forming a+b
    function automatic letter_t addMod26(input letter_t a, input letter_t b);
        letter_t comp;
        comp = NUM_LETTERS - b;
        if (a >= comp) return a - comp;
        return a + b;
    endfunction

    function automatic letter_t subMod26(input letter_t a, input letter_t b);
        if (a >= b) return a - b;
        return a + (NUM_LETTERS - b);
    endfunction

    function automatic letter_t incMod26(input letter_t a);
        if (a == LAST_LETTER) return 5'd0;
        return a + 5'd1;
    endfunction

endpackage

// File: rtl/rotor_map.sv
// One substitution through a rotor (either direction) or the reflector,
// shifted by the rotor position; shared by every stage of the core.
module rotor_map
    import enigma_pkg::*;
(
    input  logic [4:0] i_letter,
    input  logic [4:0] i_pos,
    input  logic [1:0] i_sel,
    input  logic       i_inv,
    output logic [4:0] o_letter
);

    rotor_e  w_sel;
    letter_t w_shifted;
    letter_t w_wired;

    assign w_sel = rotor_e'(i_sel);

    always_comb begin
        w_shifted = addMod26(i_letter, i_pos);
        w_wired   = w_shifted;
        case (w_sel)
            ROT_I:   w_wired = i_inv ? ROTOR_I_INV[w_shifted]   : ROTOR_I_FWD[w_shifted];
            ROT_II:  w_wired = i_inv ? ROTOR_II_INV[w_shifted]  : ROTOR_II_FWD[w_shifted];
            ROT_III: w_wired = i_inv ? ROTOR_III_INV[w_shifted] : ROTOR_III_FWD[w_shifted];
            default: w_wired = REFLECTOR_B[w_shifted];
        endcase
        o_letter = subMod26(w_wired, i_pos);
    end

endmodule

// File: rtl/enigma_core.sv
// Three-rotor Enigma engine: steps on a clean keypress, then walks one letter
// through rotors/reflector one stage per cycle. ENIGMA_ROTOR_SET_EN adds a rotor load port.
module enigma_core
    import enigma_pkg::*;
#(
    parameter int INIT_R = 0,
    parameter int INIT_M = 0,
    parameter int INIT_L = 0
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [25:0] key,
`ifdef ENIGMA_ROTOR_SET_EN
    input  logic        set_en,
    input  logic [1:0]  set_sel,
    input  logic [4:0]  set_pos,
`endif
    output logic [25:0] lamp,
    output logic [4:0]  state1,
    output logic [4:0]  state2,
    output logic [4:0]  state3,
    output logic        busy
);

    localparam letter_t RESET_R = letter_t'(INIT_R);
    localparam letter_t RESET_M = letter_t'(INIT_M);
    localparam letter_t RESET_L = letter_t'(INIT_L);

    state_e      r_state;
    state_e      w_nextState;
    logic [25:0] r_keyQ;
    logic [25:0] r_keyPrev;
    logic [25:0] r_lamp;
    letter_t     r_posR;
    letter_t     r_posM;
    letter_t     r_posL;
    letter_t     r_letter;
    letter_t     w_keyIndex;
    letter_t     w_mapPos;
    letter_t     w_mapOut;
    logic [1:0]  w_mapSel;
    logic        w_mapInv;
    logic        w_mapActive;
    logic        w_busy;
    logic        w_keyZero;
    logic        w_keyOneHot;
    logic        w_press;

    assign w_keyZero   = (r_keyQ == '0);
    assign w_keyOneHot = !w_keyZero && ((r_keyQ & (r_keyQ - 26'd1)) == '0);
    assign w_press     = (r_state == S_IDLE) && w_keyOneHot && (r_keyPrev == '0);

    always_comb begin
        w_keyIndex = '0;
        for (int i = 0; i < 26; i++) begin
            if (r_keyQ[i]) w_keyIndex = 5'(i);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_keyQ    <= '0;
            r_keyPrev <= '0;
        end else begin
            r_keyQ    <= key;
            r_keyPrev <= r_keyQ;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_nextState;
    end

    // Each substitution stage selects which rotor/position the shared map sees
    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b1;
        w_mapActive = 1'b1;
        w_mapSel    = ROT_III;
        w_mapPos    = '0;
        w_mapInv    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy      = 1'b0;
                w_mapActive = 1'b0;
                if (w_press) w_nextState = S_STEP;
            end
            S_STEP: begin
                w_mapActive = 1'b0;
                w_nextState = S_FR;
            end
            S_FR: begin
                w_mapPos    = r_posR;
                w_nextState = S_FM;
            end
            S_FM: begin
                w_mapSel    = ROT_II;
                w_mapPos    = r_posM;
                w_nextState = S_FL;
            end
            S_FL: begin
                w_mapSel    = ROT_I;
                w_mapPos    = r_posL;
                w_nextState = S_REFL;
            end
            S_REFL: begin
                w_mapSel    = ROT_REFL;
                w_nextState = S_BL;
            end
            S_BL: begin
                w_mapSel    = ROT_I;
                w_mapPos    = r_posL;
                w_mapInv    = 1'b1;
                w_nextState = S_BM;
            end
            S_BM: begin
                w_mapSel    = ROT_II;
                w_mapPos    = r_posM;
                w_mapInv    = 1'b1;
                w_nextState = S_BR;
            end
            S_BR: begin
                w_mapPos    = r_posR;
                w_mapInv    = 1'b1;
                w_nextState = S_DONE;
            end
            default: begin
                w_busy      = 1'b0;
                w_mapActive = 1'b0;
                w_nextState = S_IDLE;
            end
        endcase
    end

    rotor_map u_rotor_map (
        .i_letter (r_letter),
        .i_pos    (w_mapPos),
        .i_sel    (w_mapSel),
        .i_inv    (w_mapInv),
        .o_letter (w_mapOut)
    );

`ifdef ENIGMA_ROTOR_SET_EN
    logic w_setLoad;
    assign w_setLoad = (r_state == S_IDLE) && !w_press && set_en &&
                       (set_sel != 2'd3) && (set_pos <= LAST_LETTER);
`endif

    // Middle steps on the right notch or its own notch; the latter also drags the left rotor
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_posR   <= RESET_R;
            r_posM   <= RESET_M;
            r_posL   <= RESET_L;
            r_letter <= '0;
            r_lamp   <= '0;
        end else begin
            if (w_press)          r_letter <= w_keyIndex;
            else if (w_mapActive) r_letter <= w_mapOut;

            if (r_state == S_STEP) begin
                r_posR <= incMod26(r_posR);
                if ((r_posR == NOTCH_III) || (r_posM == NOTCH_II)) r_posM <= incMod26(r_posM);
                if (r_posM == NOTCH_II) r_posL <= incMod26(r_posL);
            end
`ifdef ENIGMA_ROTOR_SET_EN
            else if (w_setLoad) begin
                case (set_sel)
                    2'd0:    r_posR <= set_pos;
                    2'd1:    r_posM <= set_pos;
                    default: r_posL <= set_pos;
                endcase
            end
`endif

            if (r_state == S_BR) r_lamp <= w_keyZero ? '0 : (26'd1 << w_mapOut);
            else if (w_keyZero)  r_lamp <= '0;
        end
    end

    assign lamp   = r_lamp;
    assign state1 = r_posR;
    assign state2 = r_posM;
    assign state3 = r_posL;
    assign busy   = w_busy;

endmodule
